// File: rtl/multichannel_spi_slave_pkg.sv
// Shared definitions for the multichannel SPI slave.
//   state_t      : control FSM states (IDLE -> LOAD -> ACTIVE)
//   SYNC_STAGES  : flip-flops in each pin synchroniser (an edge-detect register follows)
//   bit_index()  : which bit of a word travels on the wire for a given bit count
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

    // count = number of bits already transferred in the current word.
    function automatic int unsigned bit_index(input int unsigned count,
                                              input bit          msb_first,
                                              input int unsigned width);
        return msb_first ? (width - 1 - count) : count;
    endfunction

endpackage

// File: rtl/multichannel_spi_slave_lane.sv
// One MOSI/MISO lane of the SPI slave: transmit word register, MISO driver
// and receive shift register. All timing comes from shared strobes in the top.
// Ports:
//   clock, reset  system clock, async active-high reset (MISO only)
//   clear         force MISO low (slave idle)
//   load          capture load_word as the next word to transmit
//   drive_first   with load: also put the first bit of load_word on MISO
//   shift         present the bit selected by count on MISO
//   sample        shift mosi into the receive register
//   count         bits already transferred in the current word
//   load_word     word to transmit (zero on underrun)
//   mosi          synchronised MOSI bit
//   miso          registered MISO pin
//   rx_word       receive shift register contents
module spi_lane
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  drive_first,
    input  logic                  shift,
    input  logic                  sample,
    input  logic [CNT_W-1:0]      count,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_word
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] tx_word;
    logic [IDX_W-1:0]      tx_idx;

    assign tx_idx = IDX_W'(bit_index(32'(count), MSB_FIRST, DATA_WIDTH));

    // Data registers: contents are meaningless until the FSM loads/samples them.
    always_ff @(posedge clock) begin
        if (load) begin
            tx_word <= load_word;
        end
        if (sample) begin
            if (MSB_FIRST) begin
                rx_word <= {rx_word[DATA_WIDTH-2:0], mosi};
            end else begin
                rx_word <= {mosi, rx_word[DATA_WIDTH-1:1]};
            end
        end
    end

    // count is zero during LOAD, so tx_idx already selects the first bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso <= 1'b0;
        end else if (clear) begin
            miso <= 1'b0;
        end else if (load) begin
            if (drive_first) begin
                miso <= load_word[tx_idx];
            end
        end else if (shift) begin
            miso <= tx_word[tx_idx];
        end
    end

endmodule

// File: rtl/multichannel_spi_slave.sv
// N-lane SPI slave sharing SCLK/SS, oversampled in the system clock domain.
// Ports:
//   clock, reset        system clock (>= 8x SCLK), async active-high reset
//   SCLK, SS, MOSI      asynchronous SPI pins from the master (SS active low)
//   MISO                per-lane slave output
//   cpol, cpha          SPI mode, taken into the mode register only while idle
//   tx_data/tx_valid/tx_ready  one-deep transmit holding buffer handshake
//   rx_data, rx_valid   last complete word per lane, one-cycle update pulse
//   frame_error         pulse: SS rose part-way through a word
//   tx_underrun         pulse: master clocked a word with nothing loaded
module multichannel_spi_slave
    import spi_slave_pkg::*;
#(
    parameter int N_CHANNELS = 3,
    parameter int DATA_WIDTH = 12,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  SCLK,
    input  logic                                  SS,
    input  logic [N_CHANNELS-1:0]                 MOSI,
    output logic [N_CHANNELS-1:0]                 MISO,
    input  logic                                  cpol,
    input  logic                                  cpha,
    input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] tx_data,
    input  logic                                  tx_valid,
    output logic                                  tx_ready,
    output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] rx_data,
    output logic                                  rx_valid,
    output logic                                  frame_error,
    output logic                                  tx_underrun
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    state_t                                state;
    logic [CNT_W-1:0]                      bit_cnt;
    logic                                  mode_cpol;
    logic                                  mode_cpha;
    logic                                  underrun_pend;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] hold_buf;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] load_word;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] lane_rx;

    // Index 0..SYNC_STAGES-1 are the synchroniser, index SYNC_STAGES is the
    // edge-detect register.
    logic [SYNC_STAGES:0]                  sclk_pipe;
    logic [SYNC_STAGES:0]                  ss_pipe;
    logic [SYNC_STAGES-1:0][N_CHANNELS-1:0] mosi_pipe;

    logic                  sclk_rise, sclk_fall;
    logic                  lead_ev, trail_ev, sample_ev, shift_ev;
    logic                  ss_high, ss_fall;
    logic                  in_word, sample_go, shift_go, accept;
    logic [N_CHANNELS-1:0] mosi_now;

    // Stage boundary: pin synchronisers. SS resets to "asserted" so a master
    // holding SS low across reset release cannot start a transfer until it
    // deasserts and reasserts SS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_pipe <= '0;
            ss_pipe   <= '0;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], SCLK};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-1:0], SS};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign sclk_rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_pipe[SYNC_STAGES];
    assign sclk_fall = ~sclk_pipe[SYNC_STAGES-1] & sclk_pipe[SYNC_STAGES];
    assign ss_high   = ss_pipe[SYNC_STAGES-1];
    assign ss_fall   = ~ss_pipe[SYNC_STAGES-1] & ss_pipe[SYNC_STAGES];
    assign mosi_now  = mosi_pipe[SYNC_STAGES-1];

    assign lead_ev   = mode_cpol ? sclk_fall : sclk_rise;
    assign trail_ev  = mode_cpol ? sclk_rise : sclk_fall;
    assign sample_ev = mode_cpha ? trail_ev : lead_ev;
    assign shift_ev  = mode_cpha ? lead_ev : trail_ev;

    assign in_word   = (state == ACTIVE) && (bit_cnt != CNT_LAST) && !ss_high;
    assign sample_go = in_word && sample_ev;
    assign shift_go  = in_word && shift_ev;

    // LOAD empties the buffer, so a word offered in that same cycle is taken
    // even though tx_ready may still read low.
    assign accept    = tx_valid && (tx_ready || (state == LOAD));
    assign load_word = tx_ready ? '0 : hold_buf;

    always_ff @(posedge clock) begin
        if (accept) begin
            hold_buf <= tx_data;
        end
    end

    // Stage boundary: control FSM, bit counter, handshake and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            mode_cpol     <= 1'b0;
            mode_cpha     <= 1'b0;
            underrun_pend <= 1'b0;
            tx_ready      <= 1'b1;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            frame_error   <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            tx_underrun <= 1'b0;

            if (state == LOAD) begin
                tx_ready <= !tx_valid;
            end else if (accept) begin
                tx_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    mode_cpol     <= cpol;
                    mode_cpha     <= cpha;
                    bit_cnt       <= '0;
                    underrun_pend <= 1'b0;
                    if (ss_fall) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    // A LOAD also follows the last word of every frame, so an
                    // empty buffer is only reported once the master actually
                    // samples a bit of the word.
                    underrun_pend <= tx_ready;
                    state         <= ACTIVE;
                end
                ACTIVE: begin
                    if (bit_cnt == CNT_LAST) begin
                        rx_data  <= lane_rx;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= LOAD;
                    end else if (ss_high) begin
                        frame_error   <= (bit_cnt != '0);
                        underrun_pend <= 1'b0;
                        state         <= IDLE;
                    end else if (sample_ev) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (underrun_pend) begin
                            tx_underrun   <= 1'b1;
                            underrun_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_lane
        spi_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MSB_FIRST  (MSB_FIRST),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .clear       (state == IDLE),
            .load        (state == LOAD),
            .drive_first (!mode_cpha),
            .shift       (shift_go),
            .sample      (sample_go),
            .count       (bit_cnt),
            .load_word   (load_word[ch]),
            .mosi        (mosi_now[ch]),
            .miso        (MISO[ch]),
            .rx_word     (lane_rx[ch])
        );
    end

endmodule
